// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO pointer/flag controller: depth helpers,
// pointer wrap increment, default threshold levels and the op encoding.
package fifo_pkg;

    localparam int AF_DEFAULT = 14;
    localparam int AE_DEFAULT = 2;

    // Encoded as {accepted write, accepted read}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    function automatic int depth(input int m);
        return 1 << m;
    endfunction

    function automatic int wrap_inc(input int p, input int m);
        return (p + 1) & ((1 << m) - 1);
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/addressing/flag bundle between a FIFO user and the pointer controller.
interface fifo_ctrl_if #(
    parameter int M = 4
);
    logic         wr;
    logic         rd;
    logic         wr_enable;
    logic [M-1:0] wr_addr;
    logic [M-1:0] rd_addra;
    logic [M-1:0] rd_addrb;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic [M:0]   count;
    logic         overflow;
    logic         underflow;

    modport master (
        output wr, rd,
        input  wr_enable, wr_addr, rd_addra, rd_addrb, full, empty,
               almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr, rd,
        output wr_enable, wr_addr, rd_addra, rd_addrb, full, empty,
               almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a circular FIFO over a 1W/2R register file.
// Admits push/pop requests, tracks occupancy and raises threshold/error flags.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int M        = 4,
    parameter int N        = 16,
    parameter int AF_LEVEL = AF_DEFAULT,
    parameter int AE_LEVEL = AE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    fifo_ctrl_if.slave fifo
);

    generate
        if (N != depth(M)) begin : g_bad_depth
            $error("fifo_ctrl: N must equal 2**M");
        end
    endgenerate

    localparam logic [M:0] DEPTH = (M+1)'(N);
    localparam logic [M:0] ONE   = (M+1)'(1);
    localparam logic [M:0] AF_W  = (M+1)'(AF_LEVEL);
    localparam logic [M:0] AE_W  = (M+1)'(AE_LEVEL);

    logic [M-1:0] wr_ptr_q, wr_ptr_d;
    logic [M-1:0] rd_ptr_q, rd_ptr_d;
    logic [M:0]   count_q, count_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;
    logic         af_q, af_d;
    logic         ae_q, ae_d;
    logic         ovf_q, ovf_d;
    logic         udf_q, udf_d;
    logic         do_wr, do_rd;
    op_e          op;

    function automatic logic [M-1:0] ptr_inc(input logic [M-1:0] p);
        return M'(wrap_inc(int'(p), M));
    endfunction

    always_comb begin
        // A push into a full FIFO is allowed when a pop frees the head slot
        do_wr    = fifo.wr & (~full_q | fifo.rd);
        do_rd    = fifo.rd & ~empty_q;
        op       = op_e'({do_wr, do_rd});
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        full_d   = full_q;
        empty_d  = empty_q;
        case (op)
            OP_PUSH: begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                count_d  = count_q + ONE;
                empty_d  = 1'b0;
                full_d   = (count_q + ONE == DEPTH);
            end
            OP_POP: begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                count_d  = count_q - ONE;
                full_d   = 1'b0;
                empty_d  = (count_q == ONE);
            end
            OP_BOTH: begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            default: ;
        endcase
        af_d  = (count_d >= AF_W);
        ae_d  = (count_d <= AE_W);
        ovf_d = fifo.wr & full_q & ~fifo.rd;
        udf_d = fifo.rd & empty_q & ~fifo.wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign fifo.wr_enable    = do_wr;
    assign fifo.wr_addr      = wr_ptr_q;
    assign fifo.rd_addra     = rd_ptr_q;
    assign fifo.rd_addrb     = ptr_inc(rd_ptr_q);
    assign fifo.full         = full_q;
    assign fifo.empty        = empty_q;
    assign fifo.almost_full  = af_q;
    assign fifo.almost_empty = ae_q;
    assign fifo.count        = count_q;
    assign fifo.overflow     = ovf_q;
    assign fifo.underflow    = udf_q;

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller for a circular FIFO built around the N-word, one-write/two-read register file.
- Drives the register file's write enable, write address and read address.
- Converts push/pop requests into safe pointer updates with full/empty protection, occupancy count, threshold flags and error pulses.
- Sits directly upstream of the register file. Data passes straight from producer to register file; this block controls addressing and admission only.

Parameters:
- M, 4: address bits; depth N = 2^M.
- N, 16: number of words. Must equal 2^M; the check happens at elaboration.
- AF_LEVEL, 14: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr  in  1  push request (data on register file din same cycle)
- rd  in  1  pop request (head word visible on register file douta before the edge)
- wr_enable  out  1  to register file write port; combinational
- wr_addr  out  M  write pointer; registered
- rd_addra  out  M  read pointer (head); registered
- rd_addrb  out  M  read pointer + 1 (next-head lookahead), modulo N; combinational from the pointer
- full  out  1  registered
- empty  out  1  registered
- almost_full  out  1  registered
- almost_empty  out  1  registered
- count  out  M+1  occupancy, 0..N; registered
- overflow  out  1  one-cycle pulse; registered
- underflow  out  1  one-cycle pulse; registered

Behaviour:
- Reset (async assert, sync-safe release):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0.
- Accept rules:
  - do_wr = wr & (~full | rd).
  - do_rd = rd & ~empty.
  - wr_enable = do_wr.
- Case table for (do_wr, do_rd) at each edge:
  - 1,0: wr_ptr++, count++, empty <= 0, full <= (count+1 == N).
  - 0,1: rd_ptr++, count--, full <= 0, empty <= (count-1 == 0).
  - 1,1: both pointers advance, count and full/empty unchanged.
    - Legal when full: the old head is read combinationally before the edge overwrites that slot.
  - 0,0: hold.
- Empty with wr & rd: write only; the read is rejected, with no underflow pulse (a simultaneous write is pending).
- Pointer wrap: modulo N, natural M-bit rollover from N-1 to 0.
- Latency:
  - A written word is readable on rd_addra the cycle after the write edge.
  - Flags and count update on the same edge as the pointers.
- Thresholds: almost_full and almost_empty are computed from the next-state count and registered, so they are coherent with count.
- overflow = 1 for one cycle after an edge where wr & full & ~rd.
- underflow = 1 for one cycle after an edge where rd & empty & ~wr.
- Rejected operations never move pointers or count.
- Invariants:
  - full implies count == N and wr_ptr == rd_ptr.
  - empty implies count == 0 and wr_ptr == rd_ptr.
  - full and empty are never both 1.
- Reset mid-operation: all state returns immediately to reset values. Register file contents are not cleared and are treated as stale.
- Inputs are assumed synchronous to clk. X on wr/rd outside reset is a bench error.

Decomposition:
- Shared package: fifo_pkg.
  - Functions: depth = 2^M, next-pointer wrap increment, AF/AE default levels.
  - The op-encoding localparams {IDLE, PUSH, POP, BOTH} used by the case table.
- Sub-module: fifo_top instantiates fifo_ctrl plus register_file as the integration wrapper.
  - Exposes din, wr, rd, dout (douta), dout_next (doutb) and the flags.
  - It is a separate small block, not part of this RTL.

Test Plan:
- Reset, then write 16 consecutive words 0x10..0x1F -> after the 14th write almost_full = 1; after the 16th, full = 1, count = 16, wr_addr = 0, wr_enable = 0 on a 17th wr, overflow pulses once.
- From full, pop 16 words -> data read back 0x10..0x1F in order; empty = 1 after the 16th; a 17th rd gives underflow pulse, rd_addra stays 0.
- Empty FIFO, wr = rd = 1 with din = 0xA5 -> only the write is accepted; count = 1, empty = 0, no underflow; the next cycle douta = 0xA5.
- Full FIFO, wr = rd = 1 for 4 cycles -> count stays 16, full stays 1; both pointers advance by 4 and the read data is the oldest 4 words.
- Wrap: push 10, pop 10, push 10 -> wr_addr wraps 15 to 0 and ends at 4, rd_addra = 10, rd_addrb = 11, count = 10; data intact across the wrap.
- Assert rst_n low mid-burst with count = 7 -> asynchronously count = 0, empty = 1, full = 0, pointers 0, no error pulses after release.
